// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command decoder: FSM encoding, command bytes, ack codes.
package uart_cmd_pkg;

  typedef enum logic [1:0] {StIdle, StGotB, StGotS, StGotSIdx} state_e;

  localparam logic [7:0] CmdRight = 8'h72;
  localparam logic [7:0] CmdLeft  = 8'h6C;
  localparam logic [7:0] CmdUp    = 8'h75;
  localparam logic [7:0] CmdDown  = 8'h64;
  localparam logic [7:0] CmdBtn   = 8'h42;
  localparam logic [7:0] CmdSw    = 8'h53;
  localparam logic [7:0] CmdZero  = 8'h30;
  localparam logic [7:0] AckOk    = 8'h4B;
  localparam logic [7:0] AckErr   = 8'h3F;

  // ASCII '0'..'7'
  function automatic logic is_digit(logic [7:0] b);
    return b[7:3] == 5'b00110;
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Receive-byte strobe and ack handshake between the UART front end and the decoder.
interface uart_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] ack_data;
  logic       ack_valid;
  logic       ack_ready;

  modport master (output rx_data, rx_done, ack_ready, input ack_data, ack_valid);
  modport slave  (input rx_data, rx_done, ack_ready, output ack_data, ack_valid);
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches a single-cycle trigger into a PULSE_LEN-cycle pulse; retrigger restarts the count.
module pulse_stretcher #(
  parameter int unsigned PULSE_LEN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic pulse
);
  localparam int unsigned CntW = $clog2(PULSE_LEN + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (trig) cnt_d = CntW'(PULSE_LEN);
    else if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign pulse = cnt_q != '0;
endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes ASCII command bytes into button pulses and switch levels, acking each command.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned NUM_BTN     = 4,
  parameter int unsigned NUM_SW      = 3,
  parameter int unsigned PULSE_LEN   = 1,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  uart_cmd_decoder_if.slave  bus,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_SW-1:0]  sw_state,
  output logic               ack_ovf,
  output logic [7:0]         err_cnt
);
  localparam int unsigned ToW = $clog2(TIMEOUT_CYC);
  localparam logic [3:0] NumBtnL = 4'(NUM_BTN);
  localparam logic [3:0] NumSwL  = 4'(NUM_SW);

  state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [NUM_SW-1:0] sw_q, sw_d;
  logic [ToW-1:0] to_q, to_d;
  logic ack_valid_q, ack_ovf_q;
  logic [7:0] ack_data_q, err_q;

  logic [7:0] rx;
  logic [2:0] dig;
  logic dig_ok, legacy, btn_go, accept, reject, hs;
  logic [2:0] legacy_idx, btn_idx;
  logic [NUM_BTN-1:0] btn_trig;

  assign rx     = bus.rx_data;
  assign dig    = rx[2:0];
  assign dig_ok = is_digit(rx);

  always_comb begin
    legacy     = 1'b1;
    legacy_idx = 3'd0;
    case (rx)
      CmdRight: legacy_idx = 3'd0;
      CmdLeft:  legacy_idx = 3'd1;
      CmdUp:    legacy_idx = 3'd2;
      CmdDown:  legacy_idx = 3'd3;
      default:  legacy = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sw_d    = sw_q;
    btn_go  = 1'b0;
    btn_idx = 3'd0;
    accept  = 1'b0;
    reject  = 1'b0;
    if (bus.rx_done) begin
      unique case (state_q)
        StIdle: begin
          if (rx == CmdBtn) begin
            state_d = StGotB;
          end else if (rx == CmdSw) begin
            state_d = StGotS;
          end else if (legacy) begin
            btn_idx = legacy_idx;
            if ({1'b0, legacy_idx} < NumBtnL) begin
              btn_go = 1'b1;
              accept = 1'b1;
            end else begin
              reject = 1'b1;
            end
          end else if (dig_ok && ({1'b0, dig} < NumSwL)) begin
            for (int i = 0; i < NUM_SW; i++) if (dig == 3'(i)) sw_d[i] = ~sw_q[i];
            accept = 1'b1;
          end else begin
            reject = 1'b1;
          end
        end
        StGotB: begin
          state_d = StIdle;
          btn_idx = dig;
          if (dig_ok && ({1'b0, dig} < NumBtnL)) begin
            btn_go = 1'b1;
            accept = 1'b1;
          end else begin
            reject = 1'b1;
          end
        end
        StGotS: begin
          if (dig_ok && ({1'b0, dig} < NumSwL)) begin
            idx_d   = dig;
            state_d = StGotSIdx;
          end else begin
            state_d = StIdle;
            reject  = 1'b1;
          end
        end
        StGotSIdx: begin
          state_d = StIdle;
          if (rx[7:1] == CmdZero[7:1]) begin
            for (int i = 0; i < NUM_SW; i++) if (idx_q == 3'(i)) sw_d[i] = rx[0];
            accept = 1'b1;
          end else begin
            reject = 1'b1;
          end
        end
      endcase
    end else if (state_q != StIdle && to_q == ToW'(TIMEOUT_CYC - 1)) begin
      // A byte arriving on the expiry cycle takes the branch above instead.
      state_d = StIdle;
      reject  = 1'b1;
    end
  end

  always_comb begin
    btn_trig = '0;
    for (int i = 0; i < NUM_BTN; i++) if (btn_go && btn_idx == 3'(i)) btn_trig[i] = 1'b1;
  end

  assign to_d = (bus.rx_done || state_q == StIdle) ? '0 : to_q + ToW'(1);
  assign hs   = ack_valid_q && bus.ack_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= 3'd0;
      sw_q        <= '0;
      to_q        <= '0;
      ack_valid_q <= 1'b0;
      ack_data_q  <= 8'h00;
      ack_ovf_q   <= 1'b0;
      err_q       <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sw_q    <= sw_d;
      to_q    <= to_d;
      if (accept || reject) begin
        // A same-cycle handshake frees the slot for the new ack.
        if (!ack_valid_q || hs) begin
          ack_valid_q <= 1'b1;
          ack_data_q  <= accept ? AckOk : AckErr;
        end else begin
          ack_ovf_q <= 1'b1;
        end
      end else if (hs) begin
        ack_valid_q <= 1'b0;
      end
      if (reject && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    pulse_stretcher #(.PULSE_LEN(PULSE_LEN)) u_stretch (
      .clk   (clk),
      .rst   (rst),
      .trig  (btn_trig[g]),
      .pulse (btn_pulse[g])
    );
  end

  assign sw_state      = sw_q;
  assign ack_ovf       = ack_ovf_q;
  assign err_cnt       = err_q;
  assign bus.ack_data  = ack_data_q;
  assign bus.ack_valid = ack_valid_q;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: NUM_BTN=4, NUM_SW=3, PULSE_LEN=3, TIMEOUT_CYC=100.
module tb_uart_cmd_decoder;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] btn_pulse;
  logic [2:0] sw_state;
  logic ack_ovf;
  logic [7:0] err_cnt;
  int total = 0;
  int bad = 0;

  uart_cmd_decoder_if bus ();

  uart_cmd_decoder #(
    .NUM_BTN     (4),
    .NUM_SW      (3),
    .PULSE_LEN   (3),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .btn_pulse (btn_pulse),
    .sw_state  (sw_state),
    .ack_ovf   (ack_ovf),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    step();
    bus.rx_done = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.rx_data   = 8'h00;
    bus.rx_done   = 1'b0;
    bus.ack_ready = 1'b0;
    step();
    step();
    chk("rst_btn", 32'(btn_pulse), 32'h0);
    chk("rst_sw", 32'(sw_state), 32'h0);
    chk("rst_valid", 32'(bus.ack_valid), 32'h0);
    chk("rst_data", 32'(bus.ack_data), 32'h0);
    chk("rst_ovf", 32'(ack_ovf), 32'h0);
    chk("rst_err", 32'(err_cnt), 32'h0);
    rst = 1'b0;
    step();

    // 'u' -> button 2 pulse for 3 cycles, held ack 'K'
    send(8'h75);
    chk("u_btn_c1", 32'(btn_pulse), 32'h4);
    chk("u_valid", 32'(bus.ack_valid), 32'h1);
    chk("u_data", 32'(bus.ack_data), 32'h4B);
    chk("u_err", 32'(err_cnt), 32'h0);
    step();
    chk("u_btn_c2", 32'(btn_pulse), 32'h4);
    step();
    chk("u_btn_c3", 32'(btn_pulse), 32'h4);
    chk("u_hold_data", 32'(bus.ack_data), 32'h4B);
    step();
    chk("u_btn_end", 32'(btn_pulse), 32'h0);
    bus.ack_ready = 1'b1;
    step();
    chk("u_hs_clear", 32'(bus.ack_valid), 32'h0);

    // 'S','2','1' then '2'
    send(8'h53);
    chk("s_prefix_noack", 32'(bus.ack_valid), 32'h0);
    send(8'h32);
    chk("s_idx_noack", 32'(bus.ack_valid), 32'h0);
    send(8'h31);
    chk("s21_sw", 32'(sw_state), 32'h4);
    chk("s21_ack", 32'(bus.ack_data), 32'h4B);
    chk("s21_valid", 32'(bus.ack_valid), 32'h1);
    send(8'h32);
    chk("tog2_sw", 32'(sw_state), 32'h0);
    chk("tog2_valid", 32'(bus.ack_valid), 32'h1);
    chk("tog2_ovf", 32'(ack_ovf), 32'h0);
    step();

    // 'S','5' rejected, then IDLE proven by '0' toggle
    send(8'h53);
    send(8'h35);
    chk("s5_ack", 32'(bus.ack_data), 32'h3F);
    chk("s5_sw", 32'(sw_state), 32'h0);
    chk("s5_err", 32'(err_cnt), 32'h1);
    send(8'h30);
    chk("tog0_sw", 32'(sw_state), 32'h1);
    chk("tog0_ack", 32'(bus.ack_data), 32'h4B);

    // Boundaries: 'B','4' out of range, garbage byte, 'S','1','7' bad level
    send(8'h42);
    send(8'h34);
    chk("b4_ack", 32'(bus.ack_data), 32'h3F);
    chk("b4_err", 32'(err_cnt), 32'h2);
    chk("b4_btn", 32'(btn_pulse), 32'h0);
    send(8'h78);
    chk("junk_err", 32'(err_cnt), 32'h3);
    send(8'h53);
    send(8'h31);
    send(8'h37);
    chk("s17_ack", 32'(bus.ack_data), 32'h3F);
    chk("s17_err", 32'(err_cnt), 32'h4);
    chk("s17_sw", 32'(sw_state), 32'h1);
    send(8'h33);
    chk("tog3_sw", 32'(sw_state), 32'h1);
    chk("tog3_err", 32'(err_cnt), 32'h5);
    send(8'h30);
    chk("tog0b_sw", 32'(sw_state), 32'h0);
    step();

    // Timeout: 'B' then silence; expiry on the 100th idle edge
    send(8'h42);
    repeat (99) step();
    chk("to_early", 32'(bus.ack_valid), 32'h0);
    step();
    chk("to_valid", 32'(bus.ack_valid), 32'h1);
    chk("to_data", 32'(bus.ack_data), 32'h3F);
    chk("to_err", 32'(err_cnt), 32'h6);
    send(8'h42);
    send(8'h31);
    chk("b1_btn", 32'(btn_pulse), 32'h2);
    chk("b1_ack", 32'(bus.ack_data), 32'h4B);
    chk("b1_err", 32'(err_cnt), 32'h6);
    repeat (4) step();

    // Overflow: ack pending, later acks dropped
    bus.ack_ready = 1'b0;
    send(8'h72);
    chk("r_btn", 32'(btn_pulse), 32'h1);
    chk("r_ack", 32'(bus.ack_data), 32'h4B);
    send(8'h6C);
    chk("l_btn", 32'(btn_pulse), 32'h3);
    chk("l_ovf", 32'(ack_ovf), 32'h1);
    chk("l_data_kept", 32'(bus.ack_data), 32'h4B);
    send(8'h78);
    chk("x_data_kept", 32'(bus.ack_data), 32'h4B);
    chk("x_err", 32'(err_cnt), 32'h7);
    bus.ack_ready = 1'b1;
    step();
    chk("ovf_hs_clear", 32'(bus.ack_valid), 32'h0);
    chk("ovf_sticky", 32'(ack_ovf), 32'h1);
    repeat (4) step();

    // Retrigger restarts the pulse count
    send(8'h64);
    chk("rt_c1", 32'(btn_pulse), 32'h8);
    step();
    send(8'h64);
    step();
    step();
    chk("rt_c3_after", 32'(btn_pulse), 32'h8);
    step();
    chk("rt_end", 32'(btn_pulse), 32'h0);

    // err_cnt saturation
    repeat (260) send(8'h7A);
    chk("err_sat", 32'(err_cnt), 32'hFF);

    // Reset mid-command
    send(8'h32);
    chk("pre_rst_sw", 32'(sw_state), 32'h4);
    send(8'h53);
    send(8'h31);
    rst = 1'b1;
    #1;
    chk("mid_rst_sw", 32'(sw_state), 32'h0);
    chk("mid_rst_err", 32'(err_cnt), 32'h0);
    chk("mid_rst_ovf", 32'(ack_ovf), 32'h0);
    chk("mid_rst_valid", 32'(bus.ack_valid), 32'h0);
    chk("mid_rst_data", 32'(bus.ack_data), 32'h0);
    step();
    rst = 1'b0;
    step();
    send(8'h31);
    chk("post_rst_sw", 32'(sw_state), 32'h2);
    chk("post_rst_ack", 32'(bus.ack_data), 32'h4B);
    chk("post_rst_err", 32'(err_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 Parameter NUM_BTN, default 4, number of button pulse outputs (legal 1..8).
REQ-002 Parameter NUM_SW, default 3, number of latched switch outputs (legal 1..8).
REQ-003 Parameter PULSE_LEN, default 1, button pulse width in clk cycles (legal >= 1).
REQ-004 Parameter TIMEOUT_CYC, default 1_000_000, idle cycles before a partial command is aborted (legal >= 2).
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 rx_data  input  8  received byte, valid only when rx_done=1.
REQ-008 rx_done  input  1  single-cycle strobe, one per received byte.
REQ-009 btn_pulse  output  NUM_BTN  per-channel button pulse.
REQ-010 sw_state  output  NUM_SW  per-channel latched switch level.
REQ-011 ack_data  output  8  response byte: 8'h4B 'K' accepted, 8'h3F '?' rejected.
REQ-012 ack_valid  output  1  ack_data valid; held until ack_ready.
REQ-013 ack_ready  input  1  consumer (uart_tx side) accepts ack when ack_valid&&ack_ready.
REQ-014 ack_ovf  output  1  sticky: an ack was dropped because one was still pending.
REQ-015 err_cnt  output  8  saturating count of rejected commands/timeouts.

Function
REQ-016 Single-byte commands from IDLE: 'r' 8'h72, 'l' 8'h6C, 'u' 8'h75, 'd' 8'h64 pulse button 0/1/2/3; '0'..'7' (8'h30..8'h37) toggle switch of that index.
REQ-017 Multi-byte commands: 'B' 8'h42 + digit -> pulse button[digit]; 'S' 8'h53 + digit + '0'/'1' -> set switch[digit] to 0/1.
REQ-018 FSM states: IDLE, GOT_B, GOT_S, GOT_S_IDX; bytes only processed in cycles with rx_done=1.
REQ-019 IDLE: 'B'->GOT_B, 'S'->GOT_S, single-byte command executed and stays IDLE, any other byte rejected.
REQ-020 GOT_B: digit with index < NUM_BTN -> pulse, accept, IDLE; otherwise reject, IDLE.
REQ-021 GOT_S: digit with index < NUM_SW -> latch index, GOT_S_IDX; otherwise reject, IDLE.
REQ-022 GOT_S_IDX: '0' or '1' -> write switch, accept, IDLE; otherwise reject, IDLE.
REQ-023 Legacy letter or digit whose index >= NUM_BTN / NUM_SW is rejected with no output change.
REQ-024 Command effect (pulse start, switch change) visible the cycle after the final rx_done; ack_valid rises the same cycle.
REQ-025 Button pulse: high exactly PULSE_LEN consecutive cycles; retrigger while high restarts the count from PULSE_LEN.
REQ-026 Every completed command (accept or reject) generates one ack; the 'B'/'S' prefix and the intermediate digit generate none.
REQ-027 ack_data stable while ack_valid=1 and ack_ready=0; ack_valid clears the cycle after the handshake.
REQ-028 New ack while one is pending and not handshaken that cycle: new ack dropped, ack_ovf set; handshake and new ack in same cycle: new ack loaded, no drop.
REQ-029 Timeout counter clears on each rx_done and in IDLE; reaching TIMEOUT_CYC in non-IDLE state -> IDLE, reject ack.
REQ-030 rx_done in the same cycle as timeout expiry: byte processed, timeout ignored.
REQ-031 Reject increments err_cnt, saturating at 8'hFF.

Reset
REQ-032 On rst: state IDLE, btn_pulse=0, sw_state=0, ack_valid=0, ack_data=8'h00, ack_ovf=0, err_cnt=0, all counters 0.
REQ-033 Reset mid-command or mid-pulse aborts immediately; no ack emitted for the aborted command.

Structure
REQ-034 Shared package uart_cmd_pkg holds FSM state encoding, command byte constants ('r','l','u','d','B','S','0'), and ack codes 'K'/'?'.
REQ-035 One sub-module, pulse_stretcher (counter per channel, parameter PULSE_LEN), instantiated NUM_BTN times.

Verification
REQ-036 NUM_BTN=4, PULSE_LEN=3; rx 'u' -> btn_pulse=4'b0100 for 3 cycles, ack 'K', err_cnt 0.
REQ-037 NUM_SW=3; rx 'S','2','1' then '2' -> sw_state 3'b100 then 3'b000, two 'K' acks.
REQ-038 NUM_SW=3; rx 'S','5' -> reject '?', state IDLE, sw_state unchanged, err_cnt=1.
REQ-039 TIMEOUT_CYC=100; rx 'B' then silence 100 cycles -> ack '?', IDLE; following 'B','1' -> btn_pulse[1] pulses, 'K'.
REQ-040 ack_ready=0; rx 'r' then 'l' -> ack_data stays 'K' from 'r', ack_ovf=1; ack_ready=1 -> one handshake, ack_valid drops.
REQ-041 rst asserted after 'S','1' -> all outputs reset; next byte '1' toggles sw_state[1] to 1, proving IDLE restart.
